// File: rtl/instruction_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: word width, NOP encoding,
// PC increment and fetch FSM state encodings.
package instruction_fetch_pkg;

    localparam int WORD_W = 32;
    localparam logic [WORD_W-1:0] MIPS_NOP = 32'h0000_0000;
    localparam logic [WORD_W-1:0] PC_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_STALL = 2'd2,
        ST_FLUSH = 2'd3
    } fetch_state_t;

    function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
        return addr_lsb == 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Fetch->decode handshake bundle: instruction word/PC with valid/ready, plus the
// redirect request coming back from branch/jump resolution.
interface instruction_fetch_if;
    import instruction_fetch_pkg::*;

    logic [WORD_W-1:0] ins_mem;
    logic [WORD_W-1:0] ins_pc;
    logic              ins_valid;
    logic              ins_ready;
    logic              redirect_valid;
    logic [WORD_W-1:0] redirect_pc;

    modport master (
        output ins_mem, ins_pc, ins_valid,
        input  ins_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  ins_mem, ins_pc, ins_valid,
        output ins_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/instruction_fetch_rom.sv
// Word-addressed instruction ROM with a registered, read-enabled output.
// The array contents are loaded by other means.
module instruction_fetch_rom
    import instruction_fetch_pkg::*;
#(
    parameter int    DEPTH     = 256,
    parameter string INIT_FILE = "imem.hex",
    localparam int   AW        = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              re,
    input  logic [AW-1:0]     addr,
    output logic [WORD_W-1:0] data
);

    logic [WORD_W-1:0] mem [DEPTH];

    // Output is held while re is low so a stalled word stays on the bus.
    always_ff @(posedge clk) begin
        if (rst) begin
            data <= '0;
        end else if (re) begin
            data <= mem[addr];
        end
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, ROM read and valid/ready presentation to decode, with redirects,
// stalls and sticky range/alignment errors. IFETCH_PERF_CNT_EN adds perf counters.
//   state    | meaning
//   ST_IDLE  | first cycle out of reset, no read issued yet
//   ST_FETCH | a new word (or none) is presented this cycle
//   ST_STALL | previous word refused by decode, held on the bus
//   ST_FLUSH | bubble after a taken redirect, target word being read
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter string       INIT_FILE = "imem.hex"
) (
    input  logic                clk,
    input  logic                rst,
    instruction_fetch_if.master bus,
    output logic                range_err,
    output logic                align_err,
    output logic [WORD_W-1:0]   fetch_count,
    output logic [WORD_W-1:0]   redirect_count
);

    localparam int AW = $clog2(DEPTH);

    fetch_state_t      state, state_nxt;
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] rom_q;
    logic              oor_q;
    logic              pc_oor;
    logic              running;
    logic              redir_take;
    logic              redir_bad;
    logic              fetch_en;

    assign pc_oor    = (pc[31:2] >= 30'(DEPTH));
    assign redir_bad = bus.redirect_valid && !is_word_aligned(bus.redirect_pc[1:0]);

    instruction_fetch_rom #(
        .DEPTH     (DEPTH),
        .INIT_FILE (INIT_FILE)
    ) u_rom (
        .clk  (clk),
        .rst  (rst),
        .re   (fetch_en),
        .addr (pc[AW+1:2]),
        .data (rom_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: state_nxt = ST_FETCH;
            default: begin
                if (redir_take) begin
                    state_nxt = ST_FLUSH;
                end else if (fetch_en) begin
                    state_nxt = ST_FETCH;
                end else begin
                    state_nxt = ST_STALL;
                end
            end
        endcase
    end

    // A taken redirect overrides fetching; a word on the bus with ready high is
    // still accepted by decode in that same cycle.
    always_comb begin
        running    = (state != ST_IDLE);
        redir_take = running && bus.redirect_valid && is_word_aligned(bus.redirect_pc[1:0]);
        fetch_en   = running && !redir_take && (!bus.ins_valid || bus.ins_ready);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            bus.ins_pc    <= '0;
            bus.ins_valid <= 1'b0;
            oor_q         <= 1'b0;
            range_err     <= 1'b0;
            align_err     <= 1'b0;
        end else begin
            if (redir_take) begin
                pc            <= bus.redirect_pc;
                bus.ins_valid <= 1'b0;
            end else if (fetch_en) begin
                pc            <= pc + PC_INC;
                bus.ins_pc    <= pc;
                bus.ins_valid <= 1'b1;
                oor_q         <= pc_oor;
                if (pc_oor) begin
                    range_err <= 1'b1;
                end
            end
            if (redir_bad) begin
                align_err <= 1'b1;
            end
        end
    end

    assign bus.ins_mem = oor_q ? MIPS_NOP : rom_q;

`ifdef IFETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count    <= '0;
            redirect_count <= '0;
        end else begin
            if (bus.ins_valid && bus.ins_ready) begin
                fetch_count <= fetch_count + 32'd1;
            end
            if (redir_take) begin
                redirect_count <= redirect_count + 32'd1;
            end
        end
    end
`else
    assign fetch_count    = '0;
    assign redirect_count = '0;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: a vector table for streaming, stall and
// redirect behaviour, plus hand-written sequences for range errors and reset.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    typedef struct {
        logic        ready;
        logic        rv;
        logic [31:0] rpc;
        logic        ev;
        logic [31:0] epc;
        logic [31:0] emem;
        logic        ealign;
    } vec_t;

    localparam logic [31:0] A = 32'hA000_0000;
    localparam logic [31:0] B = 32'hB000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst4 = 1'b1;
    logic        range_err, align_err, range_err4, align_err4;
    logic [31:0] fetch_count, redirect_count, fetch_count4, redirect_count4;
    int          errors = 0;
    int          checks = 0;
    vec_t        q[$];

    instruction_fetch_if bus ();
    instruction_fetch_if bus4 ();

    always #5 clk = ~clk;

    instruction_fetch #(.DEPTH(256), .RESET_PC(32'h0), .INIT_FILE("")) dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus),
        .range_err      (range_err),
        .align_err      (align_err),
        .fetch_count    (fetch_count),
        .redirect_count (redirect_count)
    );

    instruction_fetch #(.DEPTH(4), .RESET_PC(32'h0), .INIT_FILE("")) dut4 (
        .clk            (clk),
        .rst            (rst4),
        .bus            (bus4),
        .range_err      (range_err4),
        .align_err      (align_err4),
        .fetch_count    (fetch_count4),
        .redirect_count (redirect_count4)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic ready, input logic rv, input logic [31:0] rpc,
                       input logic ev, input logic [31:0] epc, input logic [31:0] emem,
                       input logic ealign);
        vec_t v;
        v.ready = ready; v.rv = rv; v.rpc = rpc;
        v.ev = ev; v.epc = epc; v.emem = emem; v.ealign = ealign;
        q.push_back(v);
    endtask

    initial begin
        logic [31:0] exp_fc, exp_rc;
        for (int i = 0; i < 256; i++) dut.u_rom.mem[i] = A + 32'(i);
        for (int i = 0; i < 4; i++) dut4.u_rom.mem[i] = B + 32'(i);
        bus.ins_ready = 1'b1;  bus.redirect_valid = 1'b0;  bus.redirect_pc = '0;
        bus4.ins_ready = 1'b1; bus4.redirect_valid = 1'b0; bus4.redirect_pc = '0;

        // ready, redirect_valid, redirect_pc | valid, pc, mem, align_err
        add(1, 0, 32'h00, 0, 32'h00, 32'h0,  0);
        add(1, 0, 32'h00, 0, 32'h00, 32'h0,  0);
        add(1, 0, 32'h00, 1, 32'h00, A + 0,  0);
        add(1, 0, 32'h00, 1, 32'h04, A + 1,  0);
        add(0, 0, 32'h00, 1, 32'h08, A + 2,  0);
        add(0, 0, 32'h00, 1, 32'h08, A + 2,  0);
        add(0, 0, 32'h00, 1, 32'h08, A + 2,  0);
        add(1, 0, 32'h00, 1, 32'h08, A + 2,  0);
        add(1, 0, 32'h00, 1, 32'h0C, A + 3,  0);
        add(1, 1, 32'h40, 1, 32'h10, A + 4,  0);
        add(1, 0, 32'h00, 0, 32'h00, 32'h0,  0);
        add(1, 0, 32'h00, 1, 32'h40, A + 16, 0);
        add(1, 1, 32'h42, 1, 32'h44, A + 17, 0);
        add(1, 0, 32'h00, 1, 32'h48, A + 18, 1);
        add(0, 0, 32'h00, 1, 32'h4C, A + 19, 1);
        add(0, 1, 32'h80, 1, 32'h4C, A + 19, 1);
        add(1, 0, 32'h00, 0, 32'h00, 32'h0,  1);
        add(1, 0, 32'h00, 1, 32'h80, A + 32, 1);
        add(1, 0, 32'h00, 1, 32'h84, A + 33, 1);
        add(0, 0, 32'h00, 1, 32'h88, A + 34, 1);

        repeat (3) @(posedge clk);
        #1;
        check("rst ins_valid", 32'(bus.ins_valid), 32'h0);
        check("rst ins_mem", bus.ins_mem, 32'h0);
        check("rst ins_pc", bus.ins_pc, 32'h0);
        check("rst range_err", 32'(range_err), 32'h0);
        check("rst align_err", 32'(align_err), 32'h0);
        check("rst fetch_count", fetch_count, 32'h0);
        check("rst redirect_count", redirect_count, 32'h0);
        rst = 1'b0;

        foreach (q[i]) begin
            bus.ins_ready      = q[i].ready;
            bus.redirect_valid = q[i].rv;
            bus.redirect_pc    = q[i].rpc;
            check($sformatf("vec%0d ins_valid", i), 32'(bus.ins_valid), 32'(q[i].ev));
            if (q[i].ev) begin
                check($sformatf("vec%0d ins_pc", i), bus.ins_pc, q[i].epc);
                check($sformatf("vec%0d ins_mem", i), bus.ins_mem, q[i].emem);
            end
            check($sformatf("vec%0d align_err", i), 32'(align_err), 32'(q[i].ealign));
            @(posedge clk);
            #1;
        end
        bus.redirect_valid = 1'b0;

        check("stall hold ins_valid", 32'(bus.ins_valid), 32'h1);
        check("stall hold ins_pc", bus.ins_pc, 32'h88);
        check("no range_err", 32'(range_err), 32'h0);
`ifdef IFETCH_PERF_CNT_EN
        exp_fc = 32'd10; exp_rc = 32'd2;
`else
        exp_fc = 32'd0;  exp_rc = 32'd0;
`endif
        check("fetch_count", fetch_count, exp_fc);
        check("redirect_count", redirect_count, exp_rc);

        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("rerst align_err", 32'(align_err), 32'h0);
        check("rerst ins_valid", 32'(bus.ins_valid), 32'h0);
        check("rerst fetch_count", fetch_count, 32'h0);
        check("rerst redirect_count", redirect_count, 32'h0);

        // DEPTH=4 instance: stream past the end of the ROM.
        rst4 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [31:0] epc, emem;
            epc  = 32'(i - 2) * 32'd4;
            emem = (i < 6) ? B + 32'(i - 2) : 32'h0;
            check($sformatf("d4 c%0d ins_valid", i), 32'(bus4.ins_valid), (i >= 2) ? 32'h1 : 32'h0);
            if (i >= 2) begin
                check($sformatf("d4 c%0d ins_pc", i), bus4.ins_pc, epc);
                check($sformatf("d4 c%0d ins_mem", i), bus4.ins_mem, emem);
            end
            check($sformatf("d4 c%0d range_err", i), 32'(range_err4), (i >= 6) ? 32'h1 : 32'h0);
            @(posedge clk);
            #1;
        end
        bus4.ins_ready = 1'b0;
        check("d4 stall ins_pc", bus4.ins_pc, 32'h18);
        @(posedge clk);
        #1;
        check("d4 stall held ins_pc", bus4.ins_pc, 32'h18);
        check("d4 stall held ins_valid", 32'(bus4.ins_valid), 32'h1);
        rst4 = 1'b1;
        @(posedge clk);
        #1;
        check("d4 rst ins_valid", 32'(bus4.ins_valid), 32'h0);
        check("d4 rst range_err", 32'(range_err4), 32'h0);
        check("d4 rst ins_pc", bus4.ins_pc, 32'h0);
        check("d4 rst ins_mem", bus4.ins_mem, 32'h0);
        check("d4 rst align_err", 32'(align_err4), 32'h0);
        check("d4 rst fetch_count", fetch_count4, 32'h0);
        check("d4 rst redirect_count", redirect_count4, 32'h0);
        rst4 = 1'b0;
        bus4.ins_ready = 1'b1;
        @(posedge clk);
        #1;
        check("d4 idle ins_valid", 32'(bus4.ins_valid), 32'h0);
        @(posedge clk);
        #1;
        check("d4 restart ins_valid", 32'(bus4.ins_valid), 32'h1);
        check("d4 restart ins_pc", bus4.ins_pc, 32'h0);
        check("d4 restart ins_mem", bus4.ins_mem, B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
